pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: two-register (front/back) PC sequencer with delayed-branch
// handling. A taken branch redirects after one delay-slot fetch; the nullify bit
// can squash that delay-slot instruction. It also tracks link writes and keeps a
// saturating count of taken branches.
module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       le,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic       br_taken,
  input  logic       br_back,
  input  logic       br_n,
  input  logic       br_link,
  input  logic [7:0] TA,
  input  logic [7:0] R,
  output logic [7:0] F_PC,
  output logic [7:0] B_PC,
  output logic       nullify,
  output logic       link_we,
  output logic [7:0] link_addr,
  output logic [7:0] taken_cnt,
  output logic [1:0] state
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);
  localparam logic [PC_W-1:0]  F_PC_RST  = PC_W'(0);
  localparam logic [PC_W-1:0]  B_PC_RST  = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SEQ    = 2'b00,
    ST_SLOT   = 2'b01,
    ST_SQUASH = 2'b10,
    ST_BAD    = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  f_pc_q, f_pc_d;
  logic [PC_W-1:0]  b_pc_q, b_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lwe_q, lwe_d;
  logic [PC_W-1:0]  laddr_q, laddr_d;
  logic             ready_c;
  logic             accept_c;
  logic             squash_c;
  logic             nullify_c;

  // Next-state, PC advance, branch acceptance and combinational strobes.
  always_comb begin
    state_d   = state_q;
    f_pc_d    = f_pc_q;
    b_pc_d    = b_pc_q;
    cnt_d     = cnt_q;
    lwe_d     = lwe_q;
    laddr_d   = laddr_q;
    ready_c   = le && rst_n && (state_q == ST_SEQ);
    accept_c  = br_valid && ready_c;
    squash_c  = br_n && (!br_taken || !br_back);
    nullify_c = le && (state_q == ST_SQUASH);

    // A stall (le=0) leaves every register untouched.
    if (le) begin
      f_pc_d = b_pc_q;
      b_pc_d = b_pc_q + PC_STEP;
      lwe_d  = 1'b0;
      case (state_q)
        ST_SEQ: begin
          if (accept_c) begin
            state_d = squash_c ? ST_SQUASH : ST_SLOT;
            lwe_d   = br_link;
            if (br_link) begin
              laddr_d = R;
            end
            if (br_taken) begin
              b_pc_d = TA;
              if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
          end
        end
        ST_SLOT:   state_d = ST_SEQ;
        ST_SQUASH: state_d = ST_SEQ;
        default:   state_d = ST_SEQ;
      endcase
    end
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SEQ;
      f_pc_q  <= F_PC_RST;
      b_pc_q  <= B_PC_RST;
      cnt_q   <= '0;
      lwe_q   <= 1'b0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      f_pc_q  <= f_pc_d;
      b_pc_q  <= b_pc_d;
      cnt_q   <= cnt_d;
      lwe_q   <= lwe_d;
      laddr_q <= laddr_d;
    end
  end

  // The link strobe is held pending across a stall and presented on the first
  // enabled cycle after acceptance, so it is never visible while le=0.
  assign br_ready  = ready_c;
  assign nullify   = nullify_c;
  assign link_we   = lwe_q && le;
  assign link_addr = laddr_q;
  assign F_PC      = f_pc_q;
  assign B_PC      = b_pc_q;
  assign taken_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scenario tasks push expected output
// snapshots to a scoreboard queue and pop/compare them against the DUT.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, le, br_valid, br_taken, br_back, br_n, br_link;
  logic [7:0] TA, R;
  logic       br_ready, nullify, link_we;
  logic [7:0] F_PC, B_PC, link_addr, taken_cnt;
  logic [1:0] state;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] b;
    logic [1:0] st;
    logic [7:0] cnt;
    logic [7:0] la;
    logic       nul;
    logic       lwe;
    logic       rdy;
  } obs_t;

  obs_t sb[$];
  obs_t got, e;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .le(le), .br_valid(br_valid), .br_ready(br_ready),
    .br_taken(br_taken), .br_back(br_back), .br_n(br_n), .br_link(br_link),
    .TA(TA), .R(R), .F_PC(F_PC), .B_PC(B_PC), .nullify(nullify),
    .link_we(link_we), .link_addr(link_addr), .taken_cnt(taken_cnt), .state(state)
  );

  function automatic obs_t sample();
    obs_t o;
    o.f = F_PC; o.b = B_PC; o.st = state; o.cnt = taken_cnt; o.la = link_addr;
    o.nul = nullify; o.lwe = link_we; o.rdy = br_ready;
    return o;
  endfunction

  function automatic obs_t mk(input logic [7:0] f, input logic [7:0] b, input logic [1:0] st,
                              input logic [7:0] cnt, input logic [7:0] la,
                              input logic nul, input logic lwe, input logic rdy);
    obs_t o;
    o.f = f; o.b = b; o.st = st; o.cnt = cnt; o.la = la; o.nul = nul; o.lwe = lwe; o.rdy = rdy;
    return o;
  endfunction

  task automatic drive(input logic l, input logic v, input logic t, input logic bk,
                       input logic n, input logic lk, input logic [7:0] ta, input logic [7:0] r);
    le = l; br_valid = v; br_taken = t; br_back = bk; br_n = n; br_link = lk; TA = ta; R = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset then advance to F_PC=0x0C, B_PC=0x10 with no branches.
  task automatic reset_to_10();
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 0, 0, 1, 8'hAA, 8'h55);
    tick(); tick();
    sb.push_back(mk(8'h00, 8'h04, 2'b00, 8'd0, 8'h00, 0, 0, 0));
    got = sample(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL reset_held got=%h exp=%h", got, e); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    sb.push_back(mk(8'h00, 8'h04, 2'b00, 8'd0, 8'h00, 0, 0, 0));
    got = sample(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL reset_release got=%h exp=%h", got, e); end
  endtask

  task automatic test_sequential();
    drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      tick();
      sb.push_back(mk(8'(4 * i), 8'(4 * i + 4), 2'b00, 8'd0, 8'h00, 0, 0, 1));
      got = sample(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL seq_%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_taken_back();
    drive(1, 1, 1, 1, 1, 0, 8'h40, 8'h00);
    sb.push_back(mk(8'h0C, 8'h10, 2'b00, 8'd0, 8'h00, 0, 0, 1));
    got = sample(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL tb_pre got=%h exp=%h", got, e); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    sb.push_back(mk(8'h10, 8'h40, 2'b01, 8'd1, 8'h00, 0, 0, 0));
    got = sample(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL tb_slot got=%h exp=%h", got, e); end
    tick();
    sb.push_back(mk(8'h40, 8'h44, 2'b00, 8'd1, 8'h00, 0, 0, 1));
    got = sample(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL tb_redirect got=%h exp=%h", got, e); end
  endtask

  task automatic test_squash_stall();
    obs_t exp_list[5];
    reset_to_10();
    drive(1, 1, 0, 0, 1, 0, 8'h77, 8'h00);
    tick();
    exp_list[0] = mk(8'h10, 8'h14, 2'b10, 8'd0, 8'h00, 0, 0, 0);
    exp_list[1] = mk(8'h10, 8'h14, 2'b10, 8'd0, 8'h00, 0, 0, 0);
    exp_list[2] = mk(8'h10, 8'h14, 2'b10, 8'd0, 8'h00, 1, 0, 0);
    exp_list[3] = mk(8'h14, 8'h18, 2'b00, 8'd0, 8'h00, 0, 0, 1);
    exp_list[4] = mk(8'h18, 8'h1C, 2'b00, 8'd0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < 2) drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      else       drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      sb.push_back(exp_list[i]);
      got = sample(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL squash_%0d got=%h exp=%h", i, got, e); end
      tick();
    end
  endtask

  task automatic test_link_stall();
    obs_t exp_list[6];
    reset_to_10();
    drive(1, 1, 1, 0, 0, 1, 8'h80, 8'h1C);
    tick();
    exp_list[0] = mk(8'h10, 8'h80, 2'b01, 8'd1, 8'h1C, 0, 0, 0);
    exp_list[1] = mk(8'h10, 8'h80, 2'b01, 8'd1, 8'h1C, 0, 0, 0);
    exp_list[2] = mk(8'h10, 8'h80, 2'b01, 8'd1, 8'h1C, 0, 1, 0);
    exp_list[3] = mk(8'h80, 8'h84, 2'b00, 8'd1, 8'h1C, 0, 0, 1);
    exp_list[4] = mk(8'h84, 8'h88, 2'b00, 8'd1, 8'h1C, 0, 0, 1);
    exp_list[5] = mk(8'h88, 8'h8C, 2'b00, 8'd1, 8'h1C, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < 2) drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      else       drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      sb.push_back(exp_list[i]);
      got = sample(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL link_%0d got=%h exp=%h", i, got, e); end
      tick();
    end
  endtask

  task automatic test_reset_in_squash();
    reset_to_10();
    drive(1, 1, 0, 1, 1, 1, 8'h55, 8'h3C);
    tick();
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    #1;
    sb.push_back(mk(8'h00, 8'h04, 2'b00, 8'd0, 8'h00, 0, 0, 1));
    got = sample(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL rst_squash got=%h exp=%h", got, e); end
  endtask

  // Continuous taken branches to 0xFC: exercises wrap and counter saturation.
  task automatic test_wrap_saturate();
    logic [7:0] want_cnt;
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    drive(1, 1, 1, 0, 0, 0, 8'hFC, 8'h00);
    for (int k = 1; k <= 257; k++) begin
      tick();
      want_cnt = (k < 255) ? 8'(k) : 8'd255;
      sb.push_back(mk((k == 1) ? 8'h04 : 8'h00, 8'hFC, 2'b01, want_cnt, 8'h00, 0, 0, 0));
      got = sample(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL sat_acc_%0d got=%h exp=%h", k, got, e); end
      tick();
      sb.push_back(mk(8'hFC, 8'h00, 2'b00, want_cnt, 8'h00, 0, 0, 1));
      got = sample(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL wrap_%0d got=%h exp=%h", k, got, e); end
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    test_reset();
    test_sequential();
    test_taken_back();
    test_squash_stall();
    test_link_stall();
    test_reset_in_squash();
    test_wrap_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
